// File: rtl/mips_hazard_pkg.sv
// Shared hazard-unit types and constants for the five-stage MIPS pipeline.
// Also used by the decode-stage control unit for its Tuse/Tnew encodings.
package mips_hazard_pkg;

  localparam int unsigned TUSE_W = 2;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned REG_W  = 5;

  typedef logic [TUSE_W-1:0] tuse_t;
  typedef logic [TNEW_W-1:0] tnew_t;
  typedef logic [REG_W-1:0]  reg_t;

  localparam tuse_t TUSE_NONE = 2'd3;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W        = 4;

  // One source operand against the EX and MEM producers; $0 and unused operands never stall.
  function automatic logic src_hazard(
    input reg_t  d_reg,
    input tuse_t tuse,
    input reg_t  e_wa,
    input tnew_t e_tnew,
    input reg_t  m_wa,
    input tnew_t m_tnew
  );
    logic w_e_hit;
    logic w_m_hit;
    w_e_hit = (e_wa == d_reg) && (tuse < e_tnew);
    w_m_hit = (m_wa == d_reg) && (tuse < m_tnew);
    return (d_reg != '0) && (tuse != TUSE_NONE) && (w_e_hit || w_m_hit);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide unit busy counter: loads on start, counts down to zero.
module md_busy_counter
  import mips_hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_div,
  output logic                o_busy,
  output logic [MD_CNT_W-1:0] o_cnt
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] r_cnt;

  // A start while busy reloads; load wins over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_div ? DIV_LOAD : MULT_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_stall_gen.sv
// Decode-stage stall generator: Tuse/Tnew data hazards, MDU busy hazard,
// and a saturating stall-cycle performance counter.
module hazard_stall_gen
  import mips_hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic             D_md_use,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_tnew,
  input  logic             E_md_start,
  input  logic             E_md_div,
  output logic             stall,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic                w_stall_rs;
  logic                w_stall_rt;
  logic                w_stall_md;
  logic                w_md_busy;
  logic [MD_CNT_W-1:0] w_md_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (E_md_start),
    .i_div   (E_md_div),
    .o_busy  (w_md_busy),
    .o_cnt   (w_md_cnt)
  );

  always_comb begin
    w_stall_rs = src_hazard(D_rs, tuse_t'(D_tuse_rs), E_wa, tnew_t'(E_tnew),
                            M_wa, tnew_t'(M_tnew));
    w_stall_rt = src_hazard(D_rt, tuse_t'(D_tuse_rt), E_wa, tnew_t'(E_tnew),
                            M_wa, tnew_t'(M_tnew));
    w_stall_md = D_md_use && (w_md_busy || E_md_start);
  end

  // Gated by rst_n so no stall escapes while the pipeline is held in reset.
  assign stall   = rst_n && (w_stall_rs || w_stall_rt || w_stall_md);
  assign md_busy = w_md_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_gen.sv
// Directed bench for hazard_stall_gen: vector table plus MDU/reset/saturation sequences.
module tb_hazard_stall_gen;

  logic        clk;
  logic        rst_n;
  logic [4:0]  D_rs, D_rt, E_wa, M_wa;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_md_use, E_md_start, E_md_div;
  logic        stall, md_busy;
  logic [31:0] stall_cnt;

  logic        s4_stall, s4_busy;
  logic [3:0]  s4_cnt;

  int tests_run;
  int tests_failed;
  int exp_cnt;

  hazard_stall_gen #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .D_md_use   (D_md_use),
    .E_wa       (E_wa),
    .E_tnew     (E_tnew),
    .M_wa       (M_wa),
    .M_tnew     (M_tnew),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .stall      (stall),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  // Narrow-counter build held permanently in an rs hazard to exercise saturation.
  hazard_stall_gen #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .D_rs       (5'd8),
    .D_rt       (5'd0),
    .D_tuse_rs  (2'd1),
    .D_tuse_rt  (2'd3),
    .D_md_use   (1'b0),
    .E_wa       (5'd8),
    .E_tnew     (2'd2),
    .M_wa       (5'd0),
    .M_tnew     (2'd0),
    .E_md_start (1'b0),
    .E_md_div   (1'b0),
    .stall      (s4_stall),
    .md_busy    (s4_busy),
    .stall_cnt  (s4_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       md_use;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
    D_md_use = 1'b0; E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0;
    E_md_start = 1'b0; E_md_div = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //            name          rs rt  trs trt md ewa et mwa mt  exp
    vecs[0] = '{"lw_E_use1",    8, 0,  1,  3, 0,  8, 2,  0, 0, 1'b1};
    vecs[1] = '{"lw_M_use1",    8, 0,  1,  3, 0,  0, 0,  8, 1, 1'b0};
    vecs[2] = '{"reg0",         0, 0,  0,  3, 0,  0, 2,  0, 0, 1'b0};
    vecs[3] = '{"rt_unused",    0, 9,  3,  3, 0,  9, 2,  0, 0, 1'b0};
    vecs[4] = '{"rt_E_use0",    0, 9,  3,  0, 0,  9, 1,  0, 0, 1'b1};
    vecs[5] = '{"eq_tuse_tnew", 5, 0,  2,  3, 0,  5, 2,  0, 0, 1'b0};
    vecs[6] = '{"rs_M_use0",    5, 0,  0,  3, 0,  0, 0,  5, 1, 1'b1};
    vecs[7] = '{"rs_M_eq",      5, 0,  1,  3, 0,  0, 0,  5, 1, 1'b0};
    vecs[8] = '{"md_idle",      0, 0,  3,  3, 1,  0, 0,  0, 0, 1'b0};
    vecs[9] = '{"reg_differ",   3, 0,  0,  3, 0,  4, 2,  0, 0, 1'b0};

    // Reset with hazards present: stall must be forced low.
    rst_n = 1'b0;
    idle();
    D_rs = 5'd8; D_tuse_rs = 2'd1; E_wa = 5'd8; E_tnew = 2'd2;
    D_md_use = 1'b1; E_md_start = 1'b1;
    #3;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_cnt4", {28'd0, s4_cnt}, 32'd0);
    tick();
    chk("rst_busy_after_edge", {31'd0, md_busy}, 32'd0);
    idle();
    rst_n = 1'b1;
    #1;

    // Saturation in the CNT_W=4 build.
    for (int unsigned i = 0; i < 14; i++) tick();
    chk("sat4_at14", {28'd0, s4_cnt}, 32'd14);
    for (int unsigned i = 0; i < 6; i++) tick();
    chk("sat4_hold15", {28'd0, s4_cnt}, 32'd15);
    chk("sat4_stall", {31'd0, s4_stall}, 32'd1);
    chk("idle_cnt", stall_cnt, 32'd0);

    // Table of combinational data-hazard vectors.
    exp_cnt = 0;
    foreach (vecs[i]) begin
      D_rs = vecs[i].rs; D_rt = vecs[i].rt;
      D_tuse_rs = vecs[i].tuse_rs; D_tuse_rt = vecs[i].tuse_rt;
      D_md_use = vecs[i].md_use;
      E_wa = vecs[i].e_wa; E_tnew = vecs[i].e_tnew;
      M_wa = vecs[i].m_wa; M_tnew = vecs[i].m_tnew;
      E_md_start = 1'b0; E_md_div = 1'b0;
      #1;
      chk(vecs[i].name, {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      if (vecs[i].exp_stall) exp_cnt++;
      tick();
    end
    idle();
    #1;
    chk("table_cnt", stall_cnt, 32'(exp_cnt));

    // Mult start with mflo already in D: 6 stall cycles, 5 busy cycles.
    E_md_start = 1'b1; E_md_div = 1'b0; D_md_use = 1'b1;
    #1;
    chk("mult_start_stall", {31'd0, stall}, 32'd1);
    chk("mult_start_notbusy", {31'd0, md_busy}, 32'd0);
    tick();
    E_md_start = 1'b0;
    exp_cnt++;
    for (int unsigned i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("mult_busy_%0d", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("mult_stall_%0d", i), {31'd0, stall}, 32'd1);
      tick();
      exp_cnt++;
    end
    chk("mult_done_busy", {31'd0, md_busy}, 32'd0);
    chk("mult_done_stall", {31'd0, stall}, 32'd0);
    chk("mult_cnt", stall_cnt, 32'(exp_cnt));

    // Data and MDU hazard together: one stall, counter +1.
    D_rs = 5'd8; D_tuse_rs = 2'd1; E_wa = 5'd8; E_tnew = 2'd2;
    D_md_use = 1'b1; E_md_start = 1'b1; E_md_div = 1'b0;
    #1;
    chk("both_stall", {31'd0, stall}, 32'd1);
    tick();
    exp_cnt++;
    idle();
    #1;
    chk("both_cnt", stall_cnt, 32'(exp_cnt));
    for (int unsigned i = 0; i < 6; i++) tick();
    chk("both_drain_busy", {31'd0, md_busy}, 32'd0);

    // Div start, then asynchronous reset during the 4th busy cycle.
    E_md_start = 1'b1; E_md_div = 1'b1;
    tick();
    E_md_start = 1'b0; E_md_div = 1'b0;
    D_md_use = 1'b1;
    for (int unsigned i = 0; i < 3; i++) tick();
    chk("div_busy_c4", {31'd0, md_busy}, 32'd1);
    chk("div_stall_c4", {31'd0, stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("div_rst_busy", {31'd0, md_busy}, 32'd0);
    chk("div_rst_stall", {31'd0, stall}, 32'd0);
    chk("div_rst_cnt", stall_cnt, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("div_post_busy", {31'd0, md_busy}, 32'd0);
    chk("div_post_stall", {31'd0, stall}, 32'd0);
    chk("div_post_cnt", stall_cnt, 32'd0);

    // Div full length: 10 busy cycles.
    idle();
    E_md_start = 1'b1; E_md_div = 1'b1;
    tick();
    E_md_start = 1'b0; E_md_div = 1'b0;
    for (int unsigned i = 0; i < 9; i++) tick();
    chk("div_busy_c10", {31'd0, md_busy}, 32'd1);
    tick();
    chk("div_done_busy", {31'd0, md_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
